// File: rtl/shift_sequencer.sv
// Multi-cycle N-position shifter built from a single-position shifter, one step per clock.
// Latency: done pulses the cycle after edge N (N=0 for op none/amount 0); start is ignored while busy.

module shifter (
    input  logic [15:0] in,
    input  logic [1:0]  shift,
    output logic [15:0] out
);
    always_comb begin
        case (shift)
            2'b01:   out = {in[14:0], 1'b0};
            2'b10:   out = {1'b0, in[15:1]};
            2'b11:   out = {in[15], in[15:1]};
            default: out = in;
        endcase
    end
endmodule

module shift_sequencer #(
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      din,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [15:0]      dout
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [15:0]      dout_q, dout_d;
    logic [15:0]      step_dat;

    shifter u_shifter (
        .in    (acc_q),
        .shift (op_q),
        .out   (step_dat)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = din;
                    op_d  = op;
                    cnt_d = amount;
                    // Zero-length or no-op requests complete without entering SHIFT.
                    if (amount == '0 || op == 2'b00) begin
                        state_d = ST_DONE;
                        dout_d  = din;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = step_dat;
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                    dout_d  = step_dat;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= 2'b00;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dout_q  <= dout_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign dout = dout_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized bench for shift_sequencer against an arithmetic shift model.

module tb_shift_sequencer;
    localparam int AMT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [15:0]      din;
    logic [1:0]       op;
    logic [AMT_W-1:0] amount;
    logic             busy;
    logic             done;
    logic [15:0]      dout;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_dout;

    shift_sequencer #(.AMT_W(AMT_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .din    (din),
        .op     (op),
        .amount (amount),
        .busy   (busy),
        .done   (done),
        .dout   (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] d, input logic [1:0] o, input int n);
        logic signed [15:0] s;
        s = d;
        case (o)
            2'b01:   return 16'(d << n);
            2'b10:   return d >> n;
            2'b11:   return 16'(s >>> n);
            default: return d;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble(input bit noisy);
        start  = noisy ? 1'($urandom % 2) : 1'b0;
        din    = 16'($urandom);
        op     = 2'($urandom);
        amount = AMT_W'($urandom);
    endtask

    // Issues one request and walks it edge by edge until back in IDLE.
    task automatic run_op(input logic [15:0] d, input logic [1:0] o,
                          input logic [AMT_W-1:0] a, input bit noisy);
        int n;
        logic [15:0] res;
        n   = (o == 2'b00) ? 0 : int'(a);
        res = model(d, o, n);
        start = 1'b1; din = d; op = o; amount = a;
        step();
        for (int j = 0; j <= n; j++) begin
            if (j < n) begin
                check("busy_shift", 32'(busy), 32'd1);
                check("done_early", 32'(done), 32'd0);
                check("dout_hold", 32'(dout), 32'(exp_dout));
            end else begin
                check("busy_done", 32'(busy), 32'd1);
                check("done_pulse", 32'(done), 32'd1);
                check("dout_result", 32'(dout), 32'(res));
                exp_dout = res;
            end
            scramble(noisy);
            if (j < n) step();
        end
        step();
        check("busy_idle", 32'(busy), 32'd0);
        check("done_clear", 32'(done), 32'd0);
        check("dout_stable", 32'(dout), 32'(exp_dout));
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; din = 16'hFFFF; op = 2'b01; amount = 4'd3;
        exp_dout = 16'h0000;
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dout", 32'(dout), 32'h0);
        start = 1'b1;
        step();
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_done", 32'(done), 32'd0);
        reset = 1'b0; start = 1'b0;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);

        run_op(16'hF0CF, 2'b01, 4'd4, 1'b0);
        run_op(16'h800D, 2'b11, 4'd3, 1'b0);
        run_op(16'h800D, 2'b10, 4'd15, 1'b0);
        run_op(16'h800D, 2'b11, 4'd15, 1'b0);
        run_op(16'h0029, 2'b01, 4'd0, 1'b0);
        run_op(16'h0029, 2'b00, 4'd7, 1'b0);
        run_op(16'h0001, 2'b01, 4'd5, 1'b1);
        run_op(16'hFFFF, 2'b10, 4'd1, 1'b0);

        start = 1'b1; din = 16'h1234; op = 2'b10; amount = 4'd10;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_dout", 32'(dout), 32'h0);
        reset = 1'b0;
        exp_dout = 16'h0000;
        step();
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        run_op(16'h1234, 2'b10, 4'd2, 1'b0);

        for (int t = 0; t < 40; t++) begin
            run_op(16'($urandom), 2'($urandom), AMT_W'($urandom), 1'($urandom % 2));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                step();
                check("gap_idle", 32'(busy), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
